// File: rtl/panel_pkg.sv
// Shared definitions for the panel row sequencer.
//  - Row geometry: ROW_BITS, COMPONENT_BITS, LEDS_PER_ROW
//  - FSM state encoding (row_state_e)
//  - Row timing helper and the row length constant at the default sizing
package panel_pkg;

  localparam int ROW_BITS       = 384;  // 16 LEDs x 3 colours x 8 bits
  localparam int COMPONENT_BITS = 8;
  localparam int LEDS_PER_ROW   = 16;
  localparam int DEF_NUM_ROWS   = 16;
  localparam int DEF_PWM_STEPS  = 256;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_CAPTURE = 4'd2,
    ST_BLOAD   = 4'd3,
    ST_BSHIFT  = 4'd4,
    ST_BLATCH  = 4'd5,
    ST_PLOAD   = 4'd6,
    ST_PSHIFT  = 4'd7,
    ST_PLATCH  = 4'd8,
    ST_ROWEND  = 4'd9
  } row_state_e;

  // Cycles from the cycle enable is sampled to ROWEND inclusive:
  // enable-sample + FETCH + CAPTURE + ROWEND, plus one load/shift/latch
  // burst for brightness and one per PWM step.
  function automatic int row_cycles(input int shift_len, input int pwm_steps);
    return 4 + (shift_len + 2) * (pwm_steps + 1);
  endfunction

  localparam int ROW_CYCLES = row_cycles(LEDS_PER_ROW, DEF_PWM_STEPS); // 4630

endpackage

// File: rtl/shift_burst_counter.sv
// Shift burst generator shared by the brightness and PWM shift phases.
//  clk, reset : clock, async active-high reset
//  start      : 1-cycle pulse; shift goes high on the following cycle
//  shift      : high for SHIFT_LEN consecutive cycles
//  done       : high on the last shift cycle so the FSM leaves without a bubble
module shift_burst_counter #(
  parameter int SHIFT_LEN = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic shift,
  output logic done
);

  localparam int              CW  = $clog2(SHIFT_LEN + 1);
  localparam logic [CW-1:0]   LEN = CW'(SHIFT_LEN);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (start)       cnt <= LEN;
    else if (cnt != '0)   cnt <= cnt - CW'(1);
  end

  assign shift = (cnt != '0);
  assign done  = (cnt == CW'(1));

endmodule

// File: rtl/panel_row_sequencer.sv
// Panel row sequencer: fetches one row from the frame buffer, then runs the
// brightness load/shift/latch and PWM_STEPS load/shift/latch bursts for it
// before advancing to the next row.
//  clk, reset      : clock, async active-high reset
//  enable          : run scan, sampled in IDLE and at ROWEND only
//  rd_addr/rd_data : frame buffer read port, data one cycle after address
//  row_colors      : captured row, held for the whole row
//  load_brightness, load_led_vals, shift, latch : panel driver controls
//  pwm_time        : current PWM step
//  blank, row_sel  : row blanking and row mux select
//  frame_done      : pulse when the last row completes
module panel_row_sequencer
  import panel_pkg::*;
#(
  parameter  int NUM_ROWS  = DEF_NUM_ROWS,
  parameter  int SHIFT_LEN = LEDS_PER_ROW,
  parameter  int PWM_STEPS = DEF_PWM_STEPS,
  localparam int ROW_W     = $clog2(NUM_ROWS),
  localparam int PWM_W     = $clog2(PWM_STEPS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic [ROW_W-1:0]    rd_addr,
  input  logic [ROW_BITS-1:0] rd_data,
  output logic [ROW_BITS-1:0] row_colors,
  output logic                load_brightness,
  output logic                load_led_vals,
  output logic                shift,
  output logic [PWM_W-1:0]    pwm_time,
  output logic                latch,
  output logic                blank,
  output logic [ROW_W-1:0]    row_sel,
  output logic                frame_done
);

  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);
  localparam logic [PWM_W-1:0] LAST_STEP = PWM_W'(PWM_STEPS - 1);

  row_state_e       state, state_nx;
  logic [ROW_W-1:0] row;
  logic             burst_start, burst_done;

  shift_burst_counter #(.SHIFT_LEN(SHIFT_LEN)) u_burst (
    .clk   (clk),
    .reset (reset),
    .start (burst_start),
    .shift (shift),
    .done  (burst_done)
  );

  // The row counter doubles as the read address; it only moves at ROWEND,
  // so the address is stable through IDLE and FETCH.
  assign rd_addr = row;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:    if (enable) state_nx = ST_FETCH;
      ST_FETCH:   state_nx = ST_CAPTURE;
      ST_CAPTURE: state_nx = ST_BLOAD;
      ST_BLOAD:   state_nx = ST_BSHIFT;
      ST_BSHIFT:  if (burst_done) state_nx = ST_BLATCH;
      ST_BLATCH:  state_nx = ST_PLOAD;
      ST_PLOAD:   state_nx = ST_PSHIFT;
      ST_PSHIFT:  if (burst_done) state_nx = ST_PLATCH;
      ST_PLATCH:  state_nx = (pwm_time == LAST_STEP) ? ST_ROWEND : ST_PLOAD;
      ST_ROWEND:  state_nx = enable ? ST_FETCH : ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Control pulses, decoded from state so they are one-hot by construction
  always_comb begin
    load_brightness = 1'b0;
    load_led_vals   = 1'b0;
    latch           = 1'b0;
    burst_start     = 1'b0;
    frame_done      = 1'b0;
    unique case (state)
      ST_BLOAD:  begin load_brightness = 1'b1; burst_start = 1'b1; end
      ST_PLOAD:  begin load_led_vals   = 1'b1; burst_start = 1'b1; end
      ST_BLATCH: latch = 1'b1;
      ST_PLATCH: latch = 1'b1;
      ST_ROWEND: frame_done = (row == LAST_ROW);
      default: ;
    endcase
  end

  // Row/step registers. pwm_time saturates at LAST_STEP rather than wrapping;
  // it is cleared at BLATCH so it is already 0 when the first PLOAD fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row        <= '0;
      row_sel    <= '0;
      row_colors <= '0;
      pwm_time   <= '0;
      blank      <= 1'b1;
    end else begin
      unique case (state)
        ST_CAPTURE: begin
          row_colors <= rd_data;
          row_sel    <= row;
        end
        ST_BLATCH: begin
          blank    <= 1'b0;
          pwm_time <= '0;
        end
        ST_PLATCH: if (pwm_time != LAST_STEP) pwm_time <= pwm_time + PWM_W'(1);
        ST_ROWEND: begin
          blank <= 1'b1;
          row   <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_panel_row_sequencer.sv
// Self-checking bench for panel_row_sequencer. A random frame buffer feeds
// the DUT; a per-row offset model derived from the row timing rules predicts
// every output each cycle.
module tb_panel_row_sequencer;

  localparam int NR      = 16;
  localparam int SL      = 16;
  localparam int PWM     = 256;
  localparam int PH      = SL + 2;            // load + shifts + latch
  localparam int ROW_CYC = 4 + PH * (PWM + 1); // enable-sample .. ROWEND

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [3:0]   rd_addr;
  logic [383:0] rd_data = '0;
  logic [383:0] row_colors;
  logic         load_brightness, load_led_vals, shift, latch, blank, frame_done;
  logic [7:0]   pwm_time;
  logic [3:0]   row_sel;

  always #5 clk = ~clk;

  panel_row_sequencer dut (
    .clk             (clk),
    .reset           (rst),
    .enable          (enable),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .row_colors      (row_colors),
    .load_brightness (load_brightness),
    .load_led_vals   (load_led_vals),
    .shift           (shift),
    .pwm_time        (pwm_time),
    .latch           (latch),
    .blank           (blank),
    .row_sel         (row_sel),
    .frame_done      (frame_done)
  );

  // frame buffer: data one cycle after address
  logic [383:0] mem [NR];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int mt = 0;            // offset within row, 0 = idle
  int mrow = 0;
  int rows_done = 0;
  logic [7:0]   mpwm = '0;
  logic [3:0]   msel = '0;
  logic [383:0] mcol = '0;
  int lb_n, llv_n, lat_n, sh_n, blow_n, mism, lb_t, first_llv;
  int idle_mism = 0, excl_viol = 0, cviol = 0, fd_total = 0;
  logic [383:0] last_colors;
  logic         last_blank;
  bit           have_last = 0;

  task automatic row_clear();
    lb_n = 0; llv_n = 0; lat_n = 0; sh_n = 0; blow_n = 0; mism = 0;
    lb_t = -1; first_llv = -1;
  endtask

  always @(negedge clk) begin : mon
    int q, j, pv;
    logic e_lb, e_llv, e_sh, e_lat, e_blank, e_fd;
    if (rst) begin
      mt = 0; mrow = 0; mpwm = '0; msel = '0; mcol = '0; have_last = 0;
    end else begin
      if ($countones({load_brightness, load_led_vals, shift, latch}) > 1) excl_viol++;
      if (have_last && row_colors !== last_colors && !last_blank) cviol++;
      last_colors = row_colors; last_blank = blank; have_last = 1;
      if (mt == 0) begin
        if ({load_brightness, load_led_vals, shift, latch, frame_done, blank} !== 6'b000001 ||
            rd_addr !== 4'(mrow) || row_sel !== msel || pwm_time !== mpwm || row_colors !== mcol)
          idle_mism++;
        if (enable) begin mt = 1; row_clear(); end
      end else begin
        e_lb = 0; e_llv = 0; e_sh = 0; e_lat = 0;
        if (mt >= 3 && mt <= ROW_CYC - 2) begin
          q = (mt - 3) % PH; j = (mt - 3) / PH;
          if (q == 0) begin if (j == 0) e_lb = 1; else e_llv = 1; end
          else if (q <= SL) e_sh = 1;
          else e_lat = 1;
        end
        e_blank = (mt < 5 + SL);
        e_fd    = (mt == ROW_CYC - 1) && (mrow == NR - 1);
        if (mt >= 5 + SL) begin
          pv = (mt - 3) / PH - 1;
          if (pv > PWM - 1) pv = PWM - 1;
          mpwm = 8'(pv);
        end
        if (mt == 3) begin
          msel = 4'(mrow); mcol = mem[mrow];
          chk($sformatf("r%0d_row_sel", rows_done), row_sel, mrow);
          chk($sformatf("r%0d_colors", rows_done), row_colors, mem[mrow]);
        end
        if ({load_brightness, load_led_vals, shift, latch, blank, frame_done} !==
            {e_lb, e_llv, e_sh, e_lat, e_blank, e_fd} ||
            rd_addr !== 4'(mrow) || row_sel !== msel || pwm_time !== mpwm || row_colors !== mcol)
          mism++;
        if (load_brightness) begin lb_n++; lb_t = mt; end
        if (load_led_vals) begin llv_n++; if (first_llv < 0) first_llv = mt; end
        if (latch) lat_n++;
        if (shift) sh_n++;
        if (!blank) blow_n++;
        if (frame_done) fd_total++;
        if (mt == ROW_CYC - 1) begin
          chk($sformatf("r%0d_lb_cnt", rows_done), lb_n, 1);
          chk($sformatf("r%0d_llv_cnt", rows_done), llv_n, PWM);
          chk($sformatf("r%0d_latch_cnt", rows_done), lat_n, PWM + 1);
          chk($sformatf("r%0d_shift_cnt", rows_done), sh_n, (PWM + 1) * SL);
          chk($sformatf("r%0d_blank_low", rows_done), blow_n, ROW_CYC - (5 + SL));
          chk($sformatf("r%0d_lb_at", rows_done), lb_t, 3);
          chk($sformatf("r%0d_first_llv_at", rows_done), first_llv, 5 + SL);
          chk($sformatf("r%0d_cycle_mism", rows_done), mism, 0);
          mrow = (mrow + 1) % NR;
          rows_done++;
          if (enable) begin mt = 1; row_clear(); end
          else mt = 0;
        end else mt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit hit;
    int k;
    rst = 1'b1; enable = 1'b0;
    for (int i = 0; i < NR; i++) begin
      for (int w = 0; w < 12; w++) mem[i][w*32 +: 32] = $urandom;
      mem[i][7:0] = 8'(i);
    end
    repeat (3) @(posedge clk); #1;
    chk("rst_blank", blank, 1);
    chk("rst_shift", shift, 0);
    chk("rst_lb", load_brightness, 0);
    chk("rst_llv", load_led_vals, 0);
    chk("rst_latch", latch, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_pwm", pwm_time, 0);
    chk("rst_row_sel", row_sel, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_colors", row_colors, 0);
    rst = 1'b0;
    repeat ($urandom_range(3, 10)) @(posedge clk); #1;

    // full frame, then into row 0 of the next frame; drop enable at step 100
    enable = 1'b1;
    hit = 0;
    for (int n = 0; n < (NR + 2) * ROW_CYC; n++) begin
      @(posedge clk); #1;
      if (rows_done == NR && pwm_time == 8'd100 && !blank) begin hit = 1; break; end
    end
    chk("reach_pwm100", hit, 1);
    enable = 1'b0;

    hit = 0;
    for (int n = 0; n < 2 * ROW_CYC; n++) begin
      @(posedge clk); #1;
      if (rows_done == NR + 1) begin hit = 1; break; end
    end
    chk("row_finish", hit, 1);
    repeat ($urandom_range(2, 5)) @(posedge clk); #1;
    chk("idle_pwm", pwm_time, 255);
    chk("idle_blank", blank, 1);
    chk("idle_rd_addr", rd_addr, 1);
    repeat ($urandom_range(20, 60)) @(posedge clk); #1;
    chk("idle_rd_addr_hold", rd_addr, 1);

    // one-cycle enable pulse starts row 1; reset it mid-PSHIFT
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    k = $urandom_range(1, 3);
    hit = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (load_led_vals && pwm_time == 8'(k)) begin hit = 1; break; end
    end
    chk("reach_pload", hit, 1);
    @(posedge clk);
    repeat ($urandom_range(0, SL - 2)) @(posedge clk);
    #1;
    chk("pre_rst_shift", shift, 1);
    chk("pre_rst_row_sel", row_sel, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_blank", blank, 1);
    chk("mid_rst_shift", shift, 0);
    chk("mid_rst_pwm", pwm_time, 0);
    chk("mid_rst_row_sel", row_sel, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    repeat (3) @(posedge clk); #1;
    chk("hold_rst_blank", blank, 1);
    chk("hold_rst_shift", shift, 0);
    chk("hold_rst_pwm", pwm_time, 0);
    chk("hold_rst_row_sel", row_sel, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk); #1;

    chk("idle_cycle_mism", idle_mism, 0);
    chk("pulse_exclusive", excl_viol, 0);
    chk("colors_only_blanked", cviol, 0);
    chk("frame_done_total", fd_total, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
